// File: rtl/data_cons_chk.sv
// data_cons_chk: receiving end of the data_prod_proc valid/ready link.
// Drives ready back to the producer (optionally with periodic backpressure),
// undoes the upstream processing on each accepted beat, checks the recovered
// value against an incrementing sequence and reports counts and lock status.
module data_cons_chk #(
    parameter int DW        = 8,
    parameter int CW        = 16,
    parameter int BP_PERIOD = 8,
    parameter int BP_LEN    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic [DW-1:0] data_in,
    output logic          ready_out,
    input  logic [1:0]    mode,
    input  logic          bypass_en,
    input  logic          bp_en,
    output logic [CW-1:0] beat_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err_flag,
    output logic          locked,
    output logic [DW-1:0] last_data
);

    localparam int BPW = (BP_PERIOD > 2) ? $clog2(BP_PERIOD) : 1;

    typedef enum logic {SYNC, CHECK} state_t;

    state_t          state_q, state_d;
    logic [BPW-1:0]  bp_cnt;
    logic [DW-1:0]   expected, exp_d;
    logic [DW-1:0]   rec;
    logic [DW-1:0]   resync;
    logic            msb_lost;
    logic            match;
    logic            accept;
    logic            err_hit;

    // Counters stop at all-ones rather than wrapping.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept = valid_in & ready_out;
    assign locked = (state_q == CHECK);

    // Free-running backpressure phase counter, wraps at BP_PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            bp_cnt <= '0;
        end else if (bp_cnt == BPW'(BP_PERIOD - 1)) begin
            bp_cnt <= '0;
        end else begin
            bp_cnt <= bp_cnt + 1'b1;
        end
    end

    // Registered ready: low during the first BP_LEN phases when backpressure is on.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_out <= 1'b0;
        end else begin
            ready_out <= !(bp_en && (bp_cnt < BPW'(BP_LEN)));
        end
    end

    // Undo upstream processing; x<<1 loses the MSB, so only the low bits are checkable.
    always_comb begin
        msb_lost = (mode == 2'b11) && !bypass_en;
        rec      = data_in;
        if (!bypass_en) begin
            case (mode)
                2'b00:   rec = data_in;
                2'b01:   rec = data_in - 1'b1;
                2'b10:   rec = ~data_in;
                default: rec = {1'b0, data_in[DW-1:1]};
            endcase
        end
        if (msb_lost) begin
            match  = (rec[DW-2:0] == expected[DW-2:0]) && !data_in[0];
            resync = {expected[DW-1], rec[DW-2:0]} + 1'b1;
        end else begin
            match  = (rec == expected);
            resync = rec + 1'b1;
        end
    end

    // Next state / expected value; a mismatch resyncs so one glitch costs one error.
    always_comb begin
        state_d = state_q;
        exp_d   = expected;
        err_hit = 1'b0;
        if (accept) begin
            case (state_q)
                SYNC: begin
                    if (!msb_lost) begin
                        exp_d   = rec + 1'b1;
                        state_d = CHECK;
                    end
                end
                default: begin
                    if (match) begin
                        exp_d = expected + 1'b1;
                    end else begin
                        err_hit = 1'b1;
                        exp_d   = resync;
                    end
                end
            endcase
        end
    end

    // State, sequence tracker and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SYNC;
            expected  <= '0;
            beat_cnt  <= '0;
            err_cnt   <= '0;
            err_flag  <= 1'b0;
            last_data <= '0;
        end else begin
            state_q  <= state_d;
            expected <= exp_d;
            if (accept) begin
                beat_cnt  <= sat_inc(beat_cnt);
                last_data <= rec;
            end
            if (err_hit) begin
                err_cnt  <= sat_inc(err_cnt);
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_cons_chk.sv
// Directed bench for data_cons_chk: reset, recovery modes, error resync,
// backpressure pattern, MSB-lost mode and counter saturation.
module tb_data_cons_chk;

    localparam int DW = 8;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ready_out;
    logic [1:0]    mode;
    logic          bypass_en;
    logic          bp_en;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_flag;
    logic          locked;
    logic [DW-1:0] last_data;

    int checks   = 0;
    int failures = 0;

    data_cons_chk #(.DW(DW), .CW(CW), .BP_PERIOD(8), .BP_LEN(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_out (ready_out),
        .mode      (mode),
        .bypass_en (bypass_en),
        .bp_en     (bp_en),
        .beat_cnt  (beat_cnt),
        .err_cnt   (err_cnt),
        .err_flag  (err_flag),
        .locked    (locked),
        .last_data (last_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic send(input logic [DW-1:0] d, input logic [1:0] m, input logic byp);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        valid_in = 1'b1;
        data_in = d;
        mode = m;
        bypass_en = byp;
        while (!acc && n < 50) begin
            acc = ready_out;
            @(posedge clk);
            #1;
            n++;
        end
        valid_in = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] d;
        rst = 1'b1; valid_in = 1'b0; data_in = '0; mode = 2'b00;
        bypass_en = 1'b0; bp_en = 1'b0;

        // 1: reset with valid high
        valid_in = 1'b1; data_in = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready_out, 0);
        chk("rst_beat", beat_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_flag", err_flag, 0);
        chk("rst_locked", locked, 0);
        chk("rst_last", last_data, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_ready", ready_out, 1);
        chk("rel_no_beat", beat_cnt, 0);
        valid_in = 1'b0;

        // 2: pass mode 0x10..0x1F
        do_reset();
        send(8'h10, 2'b00, 1'b0);
        chk("p_locked_first", locked, 1);
        for (int i = 1; i < 16; i++) send(8'h10 + 8'(i), 2'b00, 1'b0);
        chk("p_beat", beat_cnt, 16);
        chk("p_err", err_cnt, 0);
        chk("p_last", last_data, 8'h1F);

        // 3: mode 01 then mode 10, then wrap in pass mode
        do_reset();
        for (int i = 1; i <= 5; i++) send(8'(i), 2'b01, 1'b0);
        chk("m01_last", last_data, 8'h04);
        for (int i = 5; i <= 9; i++) send(~8'(i), 2'b10, 1'b0);
        chk("m10_err", err_cnt, 0);
        chk("m10_last", last_data, 8'h09);
        chk("m10_beat", beat_cnt, 10);
        do_reset();
        send(8'hFE, 2'b00, 1'b0);
        send(8'hFF, 2'b00, 1'b0);
        send(8'h00, 2'b00, 1'b0);
        send(8'h01, 2'b00, 1'b0);
        chk("wrap_err", err_cnt, 0);
        chk("wrap_last", last_data, 8'h01);

        // 4: injected glitch and resync
        do_reset();
        for (int i = 0; i < 8; i++) send(8'(i), 2'b00, 1'b0);
        chk("g_pre_flag", err_flag, 0);
        send(8'h40, 2'b00, 1'b0);
        chk("g_err", err_cnt, 1);
        chk("g_flag", err_flag, 1);
        send(8'h41, 2'b00, 1'b0);
        send(8'h42, 2'b00, 1'b0);
        chk("g_err_hold", err_cnt, 1);
        chk("g_flag_sticky", err_flag, 1);
        chk("g_beat", beat_cnt, 11);

        // 5: periodic backpressure
        bp_en = 1'b1;
        rst = 1'b1; valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        pat = 8'b1111_1000;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_ready_%0d", i), ready_out, pat[i]);
        end
        d = 8'h80;
        valid_in = 1'b1; mode = 2'b00; bypass_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            logic acc;
            data_in = d;
            acc = ready_out;
            @(posedge clk);
            #1;
            if (acc) d = d + 1'b1;
        end
        valid_in = 1'b0;
        chk("bp_beat", beat_cnt, 40);
        chk("bp_err", err_cnt, 0);
        chk("bp_last", last_data, 8'hA7);
        bp_en = 1'b0;

        // 6: mode 11 from reset stays SYNC, bypass locks, then mode 11 in CHECK
        do_reset();
        send(8'h20, 2'b11, 1'b0);
        send(8'h22, 2'b11, 1'b0);
        chk("m11_locked", locked, 0);
        chk("m11_err", err_cnt, 0);
        chk("m11_beat", beat_cnt, 2);
        chk("m11_last", last_data, 8'h11);
        send(8'h20, 2'b11, 1'b1);
        chk("byp_locked", locked, 1);
        send(8'h21, 2'b00, 1'b1);
        chk("byp_err", err_cnt, 0);
        send(8'h44, 2'b11, 1'b0);
        send(8'h46, 2'b11, 1'b0);
        chk("m11c_err", err_cnt, 0);
        chk("m11c_last", last_data, 8'h23);
        send(8'h49, 2'b11, 1'b0);
        chk("m11c_odd_err", err_cnt, 1);
        send(8'h4A, 2'b11, 1'b0);
        chk("m11c_resync", err_cnt, 1);

        // saturation of beat_cnt (CW=6)
        do_reset();
        for (int i = 0; i < 70; i++) send(8'(i), 2'b00, 1'b0);
        chk("sat_beat", beat_cnt, 63);
        chk("sat_err", err_cnt, 0);

        // mid-operation reset clears everything
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_beat", beat_cnt, 0);
        chk("mid_rst_locked", locked, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
